// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: four bursting requesters share one FIFO write port.
// A grant lasts until last/MAX_BURST/abandon, followed by one IDLE cycle to re-arbitrate.
module fifo_wr_arb #(
  parameter int D_WIDTH   = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [3:0]           last,
  input  logic [4*D_WIDTH-1:0] data_in,
  input  logic                 fifo_full,
  output logic [3:0]           gnt,
  output logic [3:0]           ack,
  output logic                 fifo_w_en,
  output logic [D_WIDTH-1:0]   fifo_data_w,
  output logic [1:0]           owner,
  output logic                 busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  gnt_q, gnt_d;

  logic [1:0]  cand [4];
  logic        sel_valid;
  logic [1:0]  sel_idx;
  logic        in_burst;
  logic        final_beat;
  logic        abandon;

  // Candidate k is the requester k positions after the round-robin pointer.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand[gi] = rr_ptr_q + 2'(gi);
    end
  endgenerate

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[cand[k]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[k];
      end
    end
  end

  assign in_burst    = (state_q == BURST);
  assign fifo_w_en   = in_burst & req[owner_q] & ~fifo_full;
  assign ack         = fifo_w_en ? (4'b0001 << owner_q) : 4'b0000;
  assign fifo_data_w = data_in[owner_q*D_WIDTH +: D_WIDTH];
  assign final_beat  = fifo_w_en & (last[owner_q] | (beat_cnt_q == 8'(MAX_BURST - 1)));
  assign abandon     = in_burst & ~req[owner_q];

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = in_burst;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    gnt_d      = gnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (sel_valid) begin
          state_d    = BURST;
          owner_d    = sel_idx;
          gnt_d      = 4'b0001 << sel_idx;
          beat_cnt_d = 8'd0;
        end
      end
      BURST: begin
        if (fifo_w_en) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        if (abandon || final_beat) begin
          state_d  = IDLE;
          gnt_d    = 4'b0000;
          rr_ptr_d = owner_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      rr_ptr_q   <= 2'd0;
      beat_cnt_q <= 8'd0;
      gnt_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_q      <= gnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: inputs change on the falling edge, outputs are checked 1ns later.
module tb_fifo_wr_arb;

  localparam int DW = 32;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [3:0]      last;
  logic [4*DW-1:0] data_in;
  logic            fifo_full;
  logic [3:0]      gnt;
  logic [3:0]      ack;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_data_w;
  logic [1:0]      owner;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  fifo_wr_arb #(.D_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .last        (last),
    .data_in     (data_in),
    .fifo_full   (fifo_full),
    .gnt         (gnt),
    .ack         (ack),
    .fifo_w_en   (fifo_w_en),
    .fifo_data_w (fifo_data_w),
    .owner       (owner),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req       = 4'hF;
    last      = 4'h0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) data_in[i*DW +: DW] = 32'hA000_0000 + 32'(i);

    // Reset wins over active requests.
    cyc();
    cyc();
    #1;
    check("rst_gnt",   32'(gnt), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_wen",   32'(fifo_w_en), 32'h0);
    check("rst_ack",   32'(ack), 32'h0);

    rst = 1'b0;
    req = 4'h0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("idle_gnt",  32'(gnt), 32'h0);
      check("idle_wen",  32'(fifo_w_en), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      cyc();
    end

    // Three-beat burst from requester 0.
    req = 4'b0001;
    #1;
    check("b3_pre_gnt", 32'(gnt), 32'h0);
    cyc();
    #1;
    check("b3_gnt",  32'(gnt), 32'h1);
    check("b3_busy", 32'(busy), 32'h1);
    check("b3_ack1", 32'(ack), 32'h1);
    check("b3_data", fifo_data_w, 32'hA000_0000);
    cyc();
    #1;
    check("b3_ack2", 32'(ack), 32'h1);
    cyc();
    last = 4'b0001;
    #1;
    check("b3_ack3", 32'(ack), 32'h1);
    check("b3_wen3", 32'(fifo_w_en), 32'h1);
    cyc();
    // Pointer moved past 0: with req 0 and 1 both up, 1 wins.
    req  = 4'b0011;
    last = 4'b0000;
    #1;
    check("b3_end_gnt",  32'(gnt), 32'h0);
    check("b3_end_busy", 32'(busy), 32'h0);
    check("b3_end_wen",  32'(fifo_w_en), 32'h0);
    cyc();
    #1;
    check("rr1_gnt",   32'(gnt), 32'h2);
    check("rr1_owner", 32'(owner), 32'h1);
    req = 4'b0000;
    #1;
    check("abandon_wen", 32'(fifo_w_en), 32'h0);
    check("abandon_ack", 32'(ack), 32'h0);
    cyc();
    #1;
    check("abandon_busy", 32'(busy), 32'h0);

    // All four requesting single-beat bursts: 0,1,2,3,0 with an idle gap each.
    rst = 1'b1;
    cyc();
    rst  = 1'b0;
    req  = 4'hF;
    last = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_idle_gnt", 32'(gnt), 32'h0);
      cyc();
      #1;
      check("rr_gnt",   32'(gnt), 32'(4'b0001 << (k % 4)));
      check("rr_ack",   32'(ack), 32'(4'b0001 << (k % 4)));
      check("rr_owner", 32'(owner), 32'(k % 4));
      cyc();
    end

    // Requester 2 with no last: capped at MB beats, then regranted after one idle cycle.
    req  = 4'b0100;
    last = 4'b0000;
    #1;
    check("max_pre_gnt", 32'(gnt), 32'h0);
    cyc();
    for (int b = 0; b < MB; b++) begin
      #1;
      check("max_ack",  32'(ack), 32'h4);
      check("max_data", fifo_data_w, 32'hA000_0002);
      cyc();
    end
    #1;
    check("max_end_gnt",  32'(gnt), 32'h0);
    check("max_end_busy", 32'(busy), 32'h0);
    cyc();
    #1;
    check("max_regrant", 32'(gnt), 32'h4);
    req = 4'b0000;
    cyc();

    // Requester 1 stalled by full for 5 cycles; last while stalled is ignored.
    req = 4'b0010;
    #1;
    check("full_pre_gnt", 32'(gnt), 32'h0);
    cyc();
    #1;
    check("full_ack1", 32'(ack), 32'h2);
    cyc();
    fifo_full = 1'b1;
    last      = 4'b0010;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("full_ack",  32'(ack), 32'h0);
      check("full_wen",  32'(fifo_w_en), 32'h0);
      check("full_gnt",  32'(gnt), 32'h2);
      check("full_busy", 32'(busy), 32'h1);
      cyc();
    end
    fifo_full = 1'b0;
    last      = 4'b0000;
    for (int b = 0; b < MB - 1; b++) begin
      #1;
      check("resume_ack", 32'(ack), 32'h2);
      cyc();
    end
    req = 4'b0000;
    #1;
    check("resume_end_gnt",  32'(gnt), 32'h0);
    check("resume_end_busy", 32'(busy), 32'h0);
    cyc();

    // Reset mid-burst of requester 3 clears the pointer: req 1 and 2 then grants 1.
    req = 4'b1000;
    #1;
    check("mid_pre_gnt", 32'(gnt), 32'h0);
    cyc();
    #1;
    check("mid_ack1",  32'(ack), 32'h8);
    check("mid_owner", 32'(owner), 32'h3);
    cyc();
    #1;
    check("mid_ack2", 32'(ack), 32'h8);
    rst = 1'b1;
    cyc();
    #1;
    check("mid_rst_gnt",   32'(gnt), 32'h0);
    check("mid_rst_busy",  32'(busy), 32'h0);
    check("mid_rst_owner", 32'(owner), 32'h0);
    check("mid_rst_wen",   32'(fifo_w_en), 32'h0);
    rst = 1'b0;
    req = 4'b0110;
    #1;
    check("post_rst_idle", 32'(gnt), 32'h0);
    cyc();
    #1;
    check("post_rst_gnt",   32'(gnt), 32'h2);
    check("post_rst_owner", 32'(owner), 32'h1);
    req = 4'b0000;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
